// File: rtl/fc_argmax_if.sv
// Handshake and result bundle between a vector producer and fc_argmax_classifier.
interface fc_argmax_if #(
   parameter int OUTPUT_SIZE = 64,
   parameter int ACTIV_BITS  = 16,
   parameter int IDX_BITS    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
);
   logic [OUTPUT_SIZE*ACTIV_BITS-1:0] data_in;
   logic                              data_valid;
   logic [ACTIV_BITS-1:0]             score_thresh;
   logic [ACTIV_BITS-1:0]             margin_thresh;
   logic                              clear_overrun;
   logic                              busy;
   logic                              result_valid;
   logic [IDX_BITS-1:0]               class_idx;
   logic [ACTIV_BITS-1:0]             class_score;
   logic [ACTIV_BITS-1:0]             class_margin;
   logic                              keyword_detected;
   logic                              overrun;

   modport master (
      output data_in, data_valid, score_thresh, margin_thresh, clear_overrun,
      input  busy, result_valid, class_idx, class_score, class_margin,
             keyword_detected, overrun
   );

   modport slave (
      input  data_in, data_valid, score_thresh, margin_thresh, clear_overrun,
      output busy, result_valid, class_idx, class_score, class_margin,
             keyword_detected, overrun
   );
endinterface

// File: rtl/fc_argmax_classifier.sv
// Serial argmax over a captured activation vector with margin and thresholded keyword detect.
// Define FC_ARGMAX_DEBOUNCE_EN to require DEBOUNCE_COUNT consecutive same-class detects.
module fc_argmax_classifier #(
   parameter int OUTPUT_SIZE    = 64,
   parameter int ACTIV_BITS     = 16,
   parameter int IDX_BITS       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1,
   parameter int DEBOUNCE_COUNT = 3
) (
   input logic         clk,
   input logic         rst_n,
   fc_argmax_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

   state_t                            state_r;
   logic [OUTPUT_SIZE*ACTIV_BITS-1:0] cap_r;
   logic [ACTIV_BITS-1:0]             score_thr_r;
   logic [ACTIV_BITS-1:0]             margin_thr_r;
   logic [IDX_BITS-1:0]               scan_k_r;
   logic [IDX_BITS-1:0]               max_idx_r;
   logic [ACTIV_BITS-1:0]             max_r;
   logic [ACTIV_BITS-1:0]             second_r;
   logic [ACTIV_BITS-1:0]             elem_s;
   logic [ACTIV_BITS-1:0]             margin_s;
   logic                              detect_s;
   logic                              kw_s;

   if (OUTPUT_SIZE < 1 || DEBOUNCE_COUNT < 1) begin : g_bad_cfg
      $error("fc_argmax_classifier: OUTPUT_SIZE and DEBOUNCE_COUNT must be >= 1");
   end

   // The capture register shifts down so the current element is always the low slice.
   assign elem_s   = cap_r[ACTIV_BITS-1:0];
   assign margin_s = max_r - second_r;
   assign detect_s = (max_r >= score_thr_r) && (margin_s >= margin_thr_r);

`ifdef FC_ARGMAX_DEBOUNCE_EN
   localparam int CNT_BITS = $clog2(DEBOUNCE_COUNT + 1);

   logic [CNT_BITS-1:0] run_cnt_r;
   logic [CNT_BITS-1:0] run_cnt_nxt_s;
   logic [IDX_BITS-1:0] last_class_r;
   logic                cont_s;

   assign cont_s = (run_cnt_r != '0) && (last_class_r == max_idx_r);

   // Next run length and fire-once decision for the result being published
   always_comb begin
      run_cnt_nxt_s = '0;
      kw_s          = 1'b0;
      if (detect_s) begin
         if (cont_s) begin
            if (run_cnt_r < CNT_BITS'(DEBOUNCE_COUNT)) begin
               run_cnt_nxt_s = run_cnt_r + CNT_BITS'(1);
            end else begin
               run_cnt_nxt_s = run_cnt_r;
            end
         end else begin
            run_cnt_nxt_s = CNT_BITS'(1);
         end
         kw_s = (run_cnt_nxt_s == CNT_BITS'(DEBOUNCE_COUNT)) &&
                !(cont_s && (run_cnt_r == CNT_BITS'(DEBOUNCE_COUNT)));
      end else begin
         run_cnt_nxt_s = '0;
         kw_s          = 1'b0;
      end
   end
`else
   assign kw_s = detect_s;
`endif

   // Capture/scan/publish FSM with registered outputs and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r              <= ST_IDLE;
         cap_r                <= '0;
         score_thr_r          <= '0;
         margin_thr_r         <= '0;
         scan_k_r             <= '0;
         max_idx_r            <= '0;
         max_r                <= '0;
         second_r             <= '0;
         bus.busy             <= 1'b0;
         bus.result_valid     <= 1'b0;
         bus.class_idx        <= '0;
         bus.class_score      <= '0;
         bus.class_margin     <= '0;
         bus.keyword_detected <= 1'b0;
         bus.overrun          <= 1'b0;
`ifdef FC_ARGMAX_DEBOUNCE_EN
         run_cnt_r            <= '0;
         last_class_r         <= '0;
`endif
      end else begin
         bus.result_valid     <= 1'b0;
         bus.keyword_detected <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.data_valid) begin
                  cap_r        <= bus.data_in;
                  score_thr_r  <= bus.score_thresh;
                  margin_thr_r <= bus.margin_thresh;
                  scan_k_r     <= '0;
                  max_idx_r    <= '0;
                  max_r        <= '0;
                  second_r     <= '0;
                  bus.busy     <= 1'b1;
                  state_r      <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               cap_r <= cap_r >> ACTIV_BITS;
               // Strict compare keeps the lower index on a tie and pulls second up to max.
               if (elem_s > max_r) begin
                  second_r  <= max_r;
                  max_r     <= elem_s;
                  max_idx_r <= scan_k_r;
               end else if (elem_s > second_r) begin
                  second_r <= elem_s;
               end
               scan_k_r <= scan_k_r + IDX_BITS'(1);
               if (scan_k_r == IDX_BITS'(OUTPUT_SIZE - 1)) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               bus.class_idx        <= max_idx_r;
               bus.class_score      <= max_r;
               bus.class_margin     <= margin_s;
               bus.result_valid     <= 1'b1;
               bus.keyword_detected <= kw_s;
               bus.busy             <= 1'b0;
               state_r              <= ST_IDLE;
`ifdef FC_ARGMAX_DEBOUNCE_EN
               run_cnt_r <= run_cnt_nxt_s;
               if (detect_s) begin
                  last_class_r <= max_idx_r;
               end
`endif
            end
            default: begin
               bus.busy <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
         if (bus.data_valid && (state_r != ST_IDLE)) begin
            bus.overrun <= 1'b1;
         end else if (bus.clear_overrun) begin
            bus.overrun <= 1'b0;
         end
      end
   end

endmodule
